route_compute_unit: RTL and testbench

- Per-input-port wormhole route stage for the AXI-Stream mesh router, generalised from the fixed XY selector.
- Decodes the target coordinates from the header flit. Computes the output port using a selectable dimension order (XY or YX). Requests that output from the router's switch allocator and holds the grant until TLAST.
- Drops malformed or off-mesh packets. Sits between the input FIFO and the crossbar demux.

---
 rtl/route_compute_unit.sv | 135 +++++++++++++
 tb/tb_route_compute_unit.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_compute_unit.sv
// Wormhole route stage: decodes the header target, picks an XY/YX output, holds the allocator grant to TLAST.
// req rises one cycle after the header; FWD is a zero-latency pass-through with s_tready = m_tready[port_sel]. RC_DROP_CNT_EN adds drop_cnt.
module route_compute_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int CHANNEL_NUMBER = 5,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int ROUTER_X       = 0,
  parameter int ROUTER_Y       = 0,
  parameter int ROUTING_MODE   = 0,
  parameter int TARGET_X_LSB   = 0,
  parameter int TARGET_Y_LSB   = 8,
  parameter int ROUTING_HEADER = 0,
  localparam int PW = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [ID_WIDTH-1:0]       s_tid,
  input  logic                      s_tlast,
  output logic [CHANNEL_NUMBER-1:0] req,
  input  logic [CHANNEL_NUMBER-1:0] gnt,
  output logic [CHANNEL_NUMBER-1:0] m_tvalid,
  input  logic [CHANNEL_NUMBER-1:0] m_tready,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [ID_WIDTH-1:0]       m_tid,
  output logic                      m_tlast,
  output logic [PW-1:0]             port_sel
`ifdef RC_DROP_CNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int XW = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
  localparam int YW = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;

  localparam logic [PW-1:0] P_LOCAL = PW'(0);
  localparam logic [PW-1:0] P_NORTH = PW'(1);
  localparam logic [PW-1:0] P_EAST  = PW'(2);
  localparam logic [PW-1:0] P_SOUTH = PW'(3);
  localparam logic [PW-1:0] P_WEST  = PW'(4);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FWD  = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]    state;
  logic [31:0]   tx, ty;
  logic [PW-1:0] x_port, y_port, route_port;
  logic          route_ok, is_hdr, xfer;

  assign tx = 32'(s_tdata[TARGET_X_LSB +: XW]);
  assign ty = 32'(s_tdata[TARGET_Y_LSB +: YW]);

  // Each dimension resolves to its own port; the dimension order picks which one wins.
  always_comb begin
    route_ok = (tx < 32'(MAX_ROUTERS_X)) && (ty < 32'(MAX_ROUTERS_Y));
    x_port   = P_LOCAL;
    y_port   = P_LOCAL;
    if (tx > 32'(ROUTER_X))      x_port = P_EAST;
    else if (tx < 32'(ROUTER_X)) x_port = P_WEST;
    if (ty > 32'(ROUTER_Y))      y_port = P_SOUTH;
    else if (ty < 32'(ROUTER_Y)) y_port = P_NORTH;
    if (ROUTING_MODE == 0) route_port = (x_port != P_LOCAL) ? x_port : y_port;
    else                   route_port = (y_port != P_LOCAL) ? y_port : x_port;
  end

  assign is_hdr  = (s_tid == ID_WIDTH'(ROUTING_HEADER));
  assign xfer    = s_tvalid && s_tready;
  assign m_tdata = s_tdata;
  assign m_tid   = s_tid;
  assign m_tlast = s_tlast;

  always_comb begin
    s_tready = 1'b0;
    m_tvalid = '0;
    case (state)
      S_IDLE: s_tready = s_tvalid && !(is_hdr && route_ok);
      S_FWD: begin
        s_tready = m_tready[port_sel];
        m_tvalid = CHANNEL_NUMBER'(s_tvalid) << port_sel;
      end
      S_DROP: s_tready = 1'b1;
      default: s_tready = 1'b0;
    endcase
  end

  // The grant is only sampled in REQ; the allocator keeps it while req is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      port_sel <= '0;
      req      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_tvalid) begin
            if (is_hdr && route_ok) begin
              state    <= S_REQ;
              port_sel <= route_port;
              req      <= CHANNEL_NUMBER'(1) << route_port;
            end else if (!s_tlast) begin
              state <= S_DROP;
            end
          end
        end
        S_REQ: if (gnt[port_sel]) state <= S_FWD;
        S_FWD: begin
          if (xfer && s_tlast) begin
            state <= S_IDLE;
            req   <= '0;
          end
        end
        default: if (s_tvalid && s_tlast) state <= S_IDLE;
      endcase
    end
  end

`ifdef RC_DROP_CNT_EN
  // Any flit consumed in IDLE is the first flit of a discarded packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if ((state == S_IDLE) && xfer && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_route_compute_unit.sv
// Bench for route_compute_unit: an XY and a YX instance on a 5x5 mesh at router (1,1), checked against a packet-level scoreboard.
`timescale 1ns/1ps
module tb_route_compute_unit;
  localparam int MX = 5;
  localparam int MY = 5;
  localparam int RX = 1;
  localparam int RY = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_tvalid, s_tlast;
  logic [31:0] s_tdata;
  logic [3:0]  s_tid;
  logic [4:0]  m_tready;
  logic        s_tready_xy, s_tready_yx, m_tlast_xy, m_tlast_yx;
  logic [4:0]  req_xy, req_yx, gnt_xy, gnt_yx, m_tvalid_xy, m_tvalid_yx;
  logic [31:0] m_tdata_xy, m_tdata_yx;
  logic [3:0]  m_tid_xy, m_tid_yx;
  logic [2:0]  port_sel_xy, port_sel_yx;
`ifdef RC_DROP_CNT_EN
  logic [15:0] drop_cnt_xy, drop_cnt_yx;
`endif

  route_compute_unit #(.MAX_ROUTERS_X(MX), .MAX_ROUTERS_Y(MY), .ROUTER_X(RX), .ROUTER_Y(RY), .ROUTING_MODE(0)) u_xy (
    .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready_xy), .s_tdata(s_tdata), .s_tid(s_tid),
    .s_tlast(s_tlast), .req(req_xy), .gnt(gnt_xy), .m_tvalid(m_tvalid_xy), .m_tready(m_tready),
    .m_tdata(m_tdata_xy), .m_tid(m_tid_xy), .m_tlast(m_tlast_xy), .port_sel(port_sel_xy)
`ifdef RC_DROP_CNT_EN
    , .drop_cnt(drop_cnt_xy)
`endif
  );

  route_compute_unit #(.MAX_ROUTERS_X(MX), .MAX_ROUTERS_Y(MY), .ROUTER_X(RX), .ROUTER_Y(RY), .ROUTING_MODE(1)) u_yx (
    .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready_yx), .s_tdata(s_tdata), .s_tid(s_tid),
    .s_tlast(s_tlast), .req(req_yx), .gnt(gnt_yx), .m_tvalid(m_tvalid_yx), .m_tready(m_tready),
    .m_tdata(m_tdata_yx), .m_tid(m_tid_yx), .m_tlast(m_tlast_yx), .port_sel(port_sel_yx)
`ifdef RC_DROP_CNT_EN
    , .drop_cnt(drop_cnt_yx)
`endif
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk, n_fail, drops_exp, alloc_mode, gnt_delay;
  bit   mon_en, rand_rdy;

  // Reference route: -1 = off-mesh, else 0 local, 1 north, 2 east, 3 south, 4 west.
  function automatic int route_of(int tx, int ty, bit yx);
    int dx, dy, px, py;
    if (tx >= MX || ty >= MY) return -1;
    dx = tx - RX;
    dy = ty - RY;
    px = (dx > 0) ? 2 : ((dx < 0) ? 4 : 0);
    py = (dy > 0) ? 3 : ((dy < 0) ? 1 : 0);
    if (!yx) return (px != 0) ? px : py;
    return (py != 0) ? py : px;
  endfunction

  function automatic logic [31:0] make_hdr(int tx, int ty);
    logic [31:0] d;
    d       = $urandom;
    d[2:0]  = tx[2:0];
    d[10:8] = ty[2:0];
    return d;
  endfunction

  // Allocator model: 0 = never grant, 1 = grant req after gnt_delay cycles, 2 = grant only the wrong ports.
  initial begin
    int gcnt;
    gcnt   = 0;
    gnt_xy = '0;
    gnt_yx = '0;
    forever begin
      @(negedge clk);
      if (alloc_mode == 2) begin
        gnt_xy = ~req_xy;
      end else if (alloc_mode == 0 || req_xy == '0) begin
        gnt_xy = '0;
        gcnt   = 0;
      end else if (gnt_xy == '0) begin
        if (gcnt >= gnt_delay) gnt_xy = req_xy;
        else gcnt++;
      end
    end
  end

  // Scoreboard: every output transfer must be the next expected flit on the expected port.
  initial begin
    exp_t       e;
    logic [4:0] oh;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (req_xy != '0) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL req_no_packet: req=%b, required 00000", req_xy);
          end else begin
            oh = 5'b00001 << exp_q[0].port;
            if (req_xy !== oh) begin
              n_fail++;
              $display("FAIL req_port: req=%b, required %b", req_xy, oh);
            end
          end
        end
        if (m_tvalid_xy != '0 && exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL mvalid_no_packet: m_tvalid=%b, required 00000", m_tvalid_xy);
        end
        if (|(m_tvalid_xy & m_tready)) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL xfer_unexpected: data=%h with nothing expected", m_tdata_xy);
          end else begin
            e  = exp_q.pop_front();
            oh = 5'b00001 << e.port;
            if (m_tvalid_xy !== oh || m_tdata_xy !== e.data || m_tid_xy !== e.id || m_tlast_xy !== e.last) begin
              n_fail++;
              $display("FAIL xfer_flit: valid=%b data=%h id=%h last=%b, required valid=%b data=%h id=%h last=%b",
                       m_tvalid_xy, m_tdata_xy, m_tid_xy, m_tlast_xy, oh, e.data, e.id, e.last);
            end
          end
        end
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    drops_exp = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  // Presents one flit until the XY instance accepts it; waited = cycles with s_tready low.
  task automatic put_flit(input logic [31:0] d, input logic [3:0] id, input logic last, input bit bub, output int waited);
    waited = 0;
    if (bub) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tdata  = $urandom;
        if (rand_rdy) m_tready = 5'($urandom);
      end
    end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tid    = id;
      s_tlast  = last;
      if (rand_rdy) m_tready = 5'($urandom);
      #1;
      if (s_tready_xy) return;
      waited++;
    end
    n_chk++;
    n_fail++;
    $display("FAIL flit_timeout: flit %h not accepted in 300 cycles, required acceptance", d);
  endtask

  task automatic send_pkt(input int tx, input int ty, input int len, input bit stray, input bit bub, output int hdr_wait);
    logic [31:0] d;
    logic [3:0]  id;
    int          p, w;
    p        = stray ? -1 : route_of(tx, ty, 1'b0);
    hdr_wait = 0;
    if (p < 0) drops_exp++;
    for (int i = 0; i < len; i++) begin
      if (i == 0) begin
        d  = make_hdr(tx, ty);
        id = stray ? 4'($urandom_range(1, 15)) : 4'(0);
      end else begin
        d  = $urandom;
        id = 4'($urandom_range(0, 15));
      end
      if (p >= 0) exp_q.push_back('{p, d, id, (i == len - 1)});
      put_flit(d, id, (i == len - 1), bub, w);
      if (i == 0) hdr_wait = w;
    end
  endtask

  task automatic test_reset;
    s_tvalid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (req_xy !== 5'b0)      begin n_fail++; $display("FAIL reset_req_xy: %b, required 00000", req_xy); end
    n_chk++; if (req_yx !== 5'b0)      begin n_fail++; $display("FAIL reset_req_yx: %b, required 00000", req_yx); end
    n_chk++; if (m_tvalid_xy !== 5'b0) begin n_fail++; $display("FAIL reset_mvalid: %b, required 00000", m_tvalid_xy); end
    n_chk++; if (s_tready_xy !== 1'b0) begin n_fail++; $display("FAIL reset_sready: %b, required 0", s_tready_xy); end
    n_chk++; if (port_sel_xy !== 3'd0) begin n_fail++; $display("FAIL reset_port_sel: %0d, required 0", port_sel_xy); end
`ifdef RC_DROP_CNT_EN
    n_chk++; if (drop_cnt_xy !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: %0d, required 0", drop_cnt_xy); end
`endif
    @(negedge clk);
    rst_n     = 1'b1;
    drops_exp = 0;
  endtask

  // Both dimension orders on fixed and random targets; wrong-port grants must not release REQ.
  task automatic test_route_table;
    int          txs[14], tys[14];
    int          tx, ty, pxy, pyx;
    logic [31:0] h;
    logic [4:0]  exy, eyx;
    txs = '{3, 1, 0, 2, 1, 4, 0, 2, 3, 5, 0, 7, 4, 1};
    tys = '{0, 1, 2, 2, 4, 1, 0, 0, 3, 0, 6, 7, 4, 5};
    mon_en     = 1'b0;
    alloc_mode = 2;
    for (int i = 0; i < 20; i++) begin
      if (i < 14) begin tx = txs[i]; ty = tys[i]; end
      else begin tx = $urandom_range(0, 7); ty = $urandom_range(0, 7); end
      do_reset();
      pxy = route_of(tx, ty, 1'b0);
      pyx = route_of(tx, ty, 1'b1);
      exy = (pxy < 0) ? 5'b0 : (5'b00001 << pxy);
      eyx = (pyx < 0) ? 5'b0 : (5'b00001 << pyx);
      h   = make_hdr(tx, ty);
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = h; s_tid = 4'd0; s_tlast = 1'b1;
      #1;
      n_chk++;
      if (s_tready_xy !== (pxy < 0)) begin
        n_fail++; $display("FAIL hdr_sready (%0d,%0d): %b, required %b", tx, ty, s_tready_xy, (pxy < 0));
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      #1;
      n_chk++; if (req_xy !== exy) begin n_fail++; $display("FAIL route_xy (%0d,%0d): req=%b, required %b", tx, ty, req_xy, exy); end
      n_chk++; if (req_yx !== eyx) begin n_fail++; $display("FAIL route_yx (%0d,%0d): req=%b, required %b", tx, ty, req_yx, eyx); end
      if (pxy >= 0) begin
        n_chk++;
        if (port_sel_xy !== 3'(pxy)) begin n_fail++; $display("FAIL port_sel (%0d,%0d): %0d, required %0d", tx, ty, port_sel_xy, pxy); end
        @(negedge clk);
        s_tvalid = 1'b1;
        #1;
        n_chk++;
        if (s_tready_xy !== 1'b0 || m_tvalid_xy !== 5'b0) begin
          n_fail++; $display("FAIL wrong_gnt (%0d,%0d): s_tready=%b m_tvalid=%b, required 0 00000", tx, ty, s_tready_xy, m_tvalid_xy);
        end
      end
    end
    alloc_mode = 1;
    do_reset();
    mon_en = 1'b1;
  endtask

  task automatic test_basic;
    int w;
    gnt_delay = 2; rand_rdy = 1'b0; m_tready = 5'h1f;
    send_pkt(3, 0, 3, 1'b0, 1'b0, w);
    idle(2);
    #1;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_drain: %0d flits missing, required 0", exp_q.size()); end
    n_chk++; if (req_xy !== 5'b0)   begin n_fail++; $display("FAIL basic_req_end: %b, required 00000", req_xy); end
  endtask

  task automatic test_local_single;
    int w;
    gnt_delay = 0; rand_rdy = 1'b0; m_tready = 5'h1f;
    send_pkt(RX, RY, 1, 1'b0, 1'b0, w);
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    n_chk++; if (req_xy !== 5'b0)   begin n_fail++; $display("FAIL single_req: %b, required 00000", req_xy); end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d flits missing, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    logic [31:0] d[5];
    logic [3:0]  id[5];
    bit          pat[4];
    int          w, idx;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    gnt_delay = 0; rand_rdy = 1'b0; m_tready = 5'h1f;
    for (int i = 0; i < 5; i++) begin
      d[i]  = (i == 0) ? make_hdr(0, 1) : $urandom;
      id[i] = (i == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      exp_q.push_back('{4, d[i], id[i], (i == 4)});
    end
    put_flit(d[0], id[0], 1'b0, 1'b0, w);
    idx = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = d[idx]; s_tid = id[idx]; s_tlast = (idx == 4);
      m_tready = pat[k] ? 5'h1f : 5'h0f;
      #1;
      n_chk++;
      if (s_tready_xy !== pat[k]) begin n_fail++; $display("FAIL bp_sready[%0d]: %b, required %b", k, s_tready_xy, pat[k]); end
      if (pat[k]) idx++;
    end
    for (int i = idx; i < 5; i++) put_flit(d[i], id[i], (i == 4), 1'b0, w);
    idle(2);
    #1;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d flits missing, required 0", exp_q.size()); end
  endtask

  task automatic test_drop;
    int w;
    rand_rdy = 1'b0; m_tready = 5'h1f; gnt_delay = 1;
    drops_exp++;
    for (int i = 0; i < 4; i++) begin
      put_flit((i == 0) ? make_hdr(5, 2) : $urandom, (i == 0) ? 4'd0 : 4'($urandom_range(0, 15)), (i == 3), 1'b0, w);
      n_chk++; if (w != 0) begin n_fail++; $display("FAIL drop_accept[%0d]: waited %0d, required 0", i, w); end
    end
    send_pkt(0, 0, 3, 1'b1, 1'b0, w);
    send_pkt(2, 1, 2, 1'b0, 1'b0, w);
    idle(2);
    #1;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drop_drain: %0d flits missing, required 0", exp_q.size()); end
`ifdef RC_DROP_CNT_EN
    n_chk++; if (drop_cnt_xy !== 16'(drops_exp)) begin n_fail++; $display("FAIL drop_cnt: %0d, required %0d", drop_cnt_xy, drops_exp); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] d[6];
    logic [3:0]  id[6];
    int          w;
    gnt_delay = 1; rand_rdy = 1'b0; m_tready = 5'h1f;
    for (int i = 0; i < 6; i++) begin
      d[i]  = (i == 0) ? make_hdr(3, 2) : $urandom;
      id[i] = (i == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{2, d[i], id[i], 1'b0});
      put_flit(d[i], id[i], 1'b0, 1'b0, w);
    end
    @(negedge clk);
    s_tvalid = 1'b1; s_tdata = d[3]; s_tid = id[3]; s_tlast = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++; if (req_xy !== 5'b0)      begin n_fail++; $display("FAIL rstmid_req: %b, required 00000", req_xy); end
    n_chk++; if (m_tvalid_xy !== 5'b0) begin n_fail++; $display("FAIL rstmid_mvalid: %b, required 00000", m_tvalid_xy); end
    @(negedge clk);
    rst_n     = 1'b1;
    drops_exp = 1;
    for (int i = 3; i < 6; i++) begin
      put_flit(d[i], id[i], (i == 5), 1'b0, w);
      n_chk++; if (w != 0) begin n_fail++; $display("FAIL rstmid_stray[%0d]: waited %0d, required 0", i, w); end
    end
    send_pkt(1, 0, 2, 1'b0, 1'b0, w);
    idle(2);
    #1;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: %0d flits missing, required 0", exp_q.size()); end
`ifdef RC_DROP_CNT_EN
    n_chk++; if (drop_cnt_xy !== 16'(drops_exp)) begin n_fail++; $display("FAIL rstmid_drop_cnt: %0d, required %0d", drop_cnt_xy, drops_exp); end
`endif
  endtask

  // Minimum latency: header held through IDLE and REQ, transferred in the third cycle.
  task automatic test_back_to_back;
    int w;
    gnt_delay = 0; rand_rdy = 1'b0; m_tready = 5'h1f;
    for (int k = 0; k < 5; k++) begin
      send_pkt($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 3), 1'b0, 1'b0, w);
      n_chk++; if (w != 2) begin n_fail++; $display("FAIL b2b_hdr_latency[%0d]: waited %0d, required 2", k, w); end
    end
    idle(2);
    #1;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain: %0d flits missing, required 0", exp_q.size()); end
  endtask

  task automatic test_random;
    int w;
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      gnt_delay = $urandom_range(0, 3);
      send_pkt($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 5), ($urandom_range(0, 4) == 0), 1'b1, w);
    end
    rand_rdy = 1'b0;
    m_tready = 5'h1f;
    idle(3);
    #1;
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain: %0d flits missing, required 0", exp_q.size()); end
`ifdef RC_DROP_CNT_EN
    n_chk++; if (drop_cnt_xy !== 16'(drops_exp)) begin n_fail++; $display("FAIL rand_drop_cnt: %0d, required %0d", drop_cnt_xy, drops_exp); end
`endif
  endtask

  initial begin
    n_chk = 0; n_fail = 0; drops_exp = 0;
    mon_en = 1'b0; rand_rdy = 1'b0; alloc_mode = 0; gnt_delay = 0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tid = '0; s_tlast = 1'b0; m_tready = 5'h1f;
    test_reset();
    test_route_table();
    test_basic();
    test_local_single();
    test_backpressure();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300us;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
